seven_segment_decoder: RTL and testbench

- Receive side of the segment interface: samples the eight segment lines A..G and DP coming off a display driver or an external panel.
- Synchronises and debounces the pattern, then decodes it back to a 4-bit value plus the error flag.
- Each newly settled character is delivered on a valid/ready output. Used for panel loopback checking and for reading the vending-machine display from a tester board.

---
 rtl/seven_segment_decoder.sv | 185 ++++++++++++++++++
 tb/tb_seven_segment_decoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_decoder.sv
// Receive side of the segment interface: synchronises and debounces an incoming
// {A..G,DP} pattern, decodes it to a 4-bit value and delivers it on valid/ready.
module seven_segment_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       E,
    input  logic       F,
    input  logic       G,
    input  logic       DP,
    input  logic       outReady,
    input  logic       clearOverrun,
    output logic       outValid,
    output logic [3:0] binaryNumber,
    output logic       isError,
    output logic       isInvalid,
    output logic       overrun
);

    localparam logic [CNT_W-1:0] StableMax = CNT_W'(STABLE_CYCLES);

    typedef enum logic [0:0] {StSettle, StHold} state_e;

    state_e           state_q, state_d;
    logic [7:0]       s1_q, s2_q;
    logic [7:0]       cand_q, cand_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       last_q, last_d;
    logic             last_valid_q, last_valid_d;
    logic             valid_q, valid_d;
    logic [3:0]       value_q, value_d;
    logic             err_q, err_d;
    logic             inv_q, inv_d;
    logic             overrun_q, overrun_d;

    logic             accept;
    logic             repeat_pat;
    logic             blank;
    logic             load;
    logic [4:0]       decoded;

    // Returns {invalid, value}; unlisted patterns decode to value 0.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        r = 5'h10;
        case (seg)
            7'b1111110: r = 5'h00;
            7'b0110000: r = 5'h01;
            7'b1101101: r = 5'h02;
            7'b1111001: r = 5'h03;
            7'b0110011: r = 5'h04;
            7'b1011011: r = 5'h05;
            7'b1011111: r = 5'h06;
            7'b1110010: r = 5'h07;
            7'b1110000: r = 5'h07;
            7'b1111111: r = 5'h08;
            7'b1111011: r = 5'h09;
            7'b1110111: r = 5'h0A;
            7'b0011111: r = 5'h0B;
            7'b1001110: r = 5'h0C;
            7'b0111101: r = 5'h0D;
            7'b1001111: r = 5'h0E;
            7'b1000111: r = 5'h0F;
            default:    r = 5'h10;
        endcase
        return r;
    endfunction

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= {A, B, C, D, E, F, G, DP};
            s2_q <= s1_q;
        end
    end

    // Stability filter: restart the count on any change, saturate at StableMax.
    always_comb begin
        cand_d  = cand_q;
        count_d = count_q;
        if (s2_q != cand_q) begin
            cand_d  = s2_q;
            count_d = CNT_W'(1);
        end else if (count_q < StableMax) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StSettle: begin
                if (count_q == StableMax) begin
                    accept  = 1'b1;
                    state_d = (s2_q != cand_q) ? StSettle : StHold;
                end
            end
            StHold: begin
                if (s2_q != cand_q) begin
                    state_d = StSettle;
                end
            end
            default: state_d = StSettle;
        endcase
    end

    assign repeat_pat = last_valid_q && (cand_q == last_q);
    assign blank      = (cand_q[7:1] == 7'b0);
    assign load       = accept && !repeat_pat && !blank;
    assign decoded    = decode(cand_q[7:1]);

    always_comb begin
        last_d       = last_q;
        last_valid_d = last_valid_q;
        valid_d      = valid_q;
        value_d      = value_q;
        err_d        = err_q;
        inv_d        = inv_q;
        overrun_d    = overrun_q;

        if (accept && !repeat_pat) begin
            last_d       = cand_q;
            last_valid_d = 1'b1;
        end

        if (clearOverrun) begin
            overrun_d = 1'b0;
        end

        if (load) begin
            valid_d = 1'b1;
            value_d = decoded[3:0];
            inv_d   = decoded[4];
            err_d   = cand_q[0];
            // Set wins over a coincident clear.
            if (valid_q && !outReady) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && outReady) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q      <= StSettle;
            cand_q       <= '0;
            count_q      <= '0;
            last_q       <= '0;
            last_valid_q <= 1'b0;
            valid_q      <= 1'b0;
            value_q      <= '0;
            err_q        <= 1'b0;
            inv_q        <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            count_q      <= count_d;
            last_q       <= last_d;
            last_valid_q <= last_valid_d;
            valid_q      <= valid_d;
            value_q      <= value_d;
            err_q        <= err_d;
            inv_q        <= inv_d;
            overrun_q    <= overrun_d;
        end
    end

    assign outValid     = valid_q;
    assign binaryNumber = value_q;
    assign isError      = err_q;
    assign isInvalid    = inv_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed bench for seven_segment_decoder; inputs change and outputs are
// sampled on the falling edge, so each step() covers exactly one rising edge.
module tb_seven_segment_decoder;

    logic       clock = 1'b0;
    logic       resetN;
    logic       A, B, C, D, E, F, G, DP;
    logic       outReady;
    logic       clearOverrun;
    logic       outValid;
    logic [3:0] binaryNumber;
    logic       isError;
    logic       isInvalid;
    logic       overrun;

    int tests_run = 0;
    int fails     = 0;

    seven_segment_decoder #(.STABLE_CYCLES(4)) dut (
        .clock        (clock),
        .resetN       (resetN),
        .A            (A),
        .B            (B),
        .C            (C),
        .D            (D),
        .E            (E),
        .F            (F),
        .G            (G),
        .DP           (DP),
        .outReady     (outReady),
        .clearOverrun (clearOverrun),
        .outValid     (outValid),
        .binaryNumber (binaryNumber),
        .isError      (isError),
        .isInvalid    (isInvalid),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic apply(input logic [6:0] seg, input logic dp);
        {A, B, C, D, E, F, G} = seg;
        DP = dp;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        outReady = 1'b0;
        clearOverrun = 1'b0;
        apply(7'b0000000, 1'b0);
        step(2);
        tests_run++;
        if ({outValid, binaryNumber, isError, isInvalid, overrun} !== 8'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 00000000",
                     {outValid, binaryNumber, isError, isInvalid, overrun});
        end
        resetN = 1'b1;
        step(12);
        tests_run++;
        if (outValid !== 1'b0) begin
            fails++;
            $display("FAIL blank_after_reset: outValid=%b want 0", outValid);
        end
    endtask

    task automatic test_basic();
        apply(7'b0110000, 1'b0);
        step(6);
        tests_run++;
        if (outValid !== 1'b0) begin
            fails++;
            $display("FAIL latency_early: outValid=%b want 0 after edge 5", outValid);
        end
        step(1);
        tests_run++;
        if ({outValid, binaryNumber, isError, isInvalid, overrun} !== {1'b1, 4'h1, 3'b000}) begin
            fails++;
            $display("FAIL basic_one: got v=%b n=%h e=%b i=%b o=%b want v=1 n=1 e=0 i=0 o=0",
                     outValid, binaryNumber, isError, isInvalid, overrun);
        end
        step(5);
        tests_run++;
        if ({outValid, binaryNumber, overrun} !== {1'b1, 4'h1, 1'b0}) begin
            fails++;
            $display("FAIL basic_hold: got v=%b n=%h o=%b want v=1 n=1 o=0",
                     outValid, binaryNumber, overrun);
        end
        outReady = 1'b1;
        step(1);
        outReady = 1'b0;
        tests_run++;
        if (outValid !== 1'b0) begin
            fails++;
            $display("FAIL basic_drain: outValid=%b want 0", outValid);
        end
    endtask

    task automatic test_glitch();
        apply(7'b1111001, 1'b0);
        step(10);
        tests_run++;
        if ({outValid, binaryNumber} !== {1'b1, 4'h3}) begin
            fails++;
            $display("FAIL glitch_first: got v=%b n=%h want v=1 n=3", outValid, binaryNumber);
        end
        outReady = 1'b1;
        step(1);
        outReady = 1'b0;
        apply(7'b1111111, 1'b0);
        step(1);
        apply(7'b1111001, 1'b0);
        step(15);
        tests_run++;
        if ({outValid, binaryNumber, overrun} !== {1'b0, 4'h3, 1'b0}) begin
            fails++;
            $display("FAIL glitch_suppressed: got v=%b n=%h o=%b want v=0 n=3 o=0",
                     outValid, binaryNumber, overrun);
        end
    endtask

    task automatic test_dp_change();
        outReady = 1'b1;
        apply(7'b1011011, 1'b0);
        step(7);
        tests_run++;
        if ({outValid, binaryNumber, isError} !== {1'b1, 4'h5, 1'b0}) begin
            fails++;
            $display("FAIL dp_first: got v=%b n=%h e=%b want v=1 n=5 e=0",
                     outValid, binaryNumber, isError);
        end
        step(1);
        tests_run++;
        if (outValid !== 1'b0) begin
            fails++;
            $display("FAIL dp_first_consumed: outValid=%b want 0", outValid);
        end
        apply(7'b1011011, 1'b1);
        step(7);
        tests_run++;
        if ({outValid, binaryNumber, isError} !== {1'b1, 4'h5, 1'b1}) begin
            fails++;
            $display("FAIL dp_second: got v=%b n=%h e=%b want v=1 n=5 e=1",
                     outValid, binaryNumber, isError);
        end
        step(1);
        outReady = 1'b0;
        tests_run++;
        if (outValid !== 1'b0) begin
            fails++;
            $display("FAIL dp_second_consumed: outValid=%b want 0", outValid);
        end
    endtask

    task automatic test_overrun();
        apply(7'b1101101, 1'b0);
        step(10);
        tests_run++;
        if ({outValid, binaryNumber, overrun} !== {1'b1, 4'h2, 1'b0}) begin
            fails++;
            $display("FAIL overrun_first: got v=%b n=%h o=%b want v=1 n=2 o=0",
                     outValid, binaryNumber, overrun);
        end
        apply(7'b1001111, 1'b0);
        step(10);
        tests_run++;
        if ({outValid, binaryNumber, overrun} !== {1'b1, 4'hE, 1'b1}) begin
            fails++;
            $display("FAIL overrun_set: got v=%b n=%h o=%b want v=1 n=e o=1",
                     outValid, binaryNumber, overrun);
        end
        clearOverrun = 1'b1;
        step(1);
        clearOverrun = 1'b0;
        tests_run++;
        if ({outValid, binaryNumber, overrun} !== {1'b1, 4'hE, 1'b0}) begin
            fails++;
            $display("FAIL overrun_clear: got v=%b n=%h o=%b want v=1 n=e o=0",
                     outValid, binaryNumber, overrun);
        end
        outReady = 1'b1;
        step(1);
        outReady = 1'b0;
    endtask

    task automatic test_invalid();
        apply(7'b0000001, 1'b0);
        step(10);
        tests_run++;
        if ({outValid, binaryNumber, isInvalid} !== {1'b1, 4'h0, 1'b1}) begin
            fails++;
            $display("FAIL invalid_first: got v=%b n=%h i=%b want v=1 n=0 i=1",
                     outValid, binaryNumber, isInvalid);
        end
        outReady = 1'b1;
        step(1);
        outReady = 1'b0;
        apply(7'b0000000, 1'b0);
        step(10);
        tests_run++;
        if (outValid !== 1'b0) begin
            fails++;
            $display("FAIL blank_no_emit: outValid=%b want 0", outValid);
        end
        apply(7'b0000001, 1'b0);
        step(10);
        tests_run++;
        if ({outValid, binaryNumber, isInvalid} !== {1'b1, 4'h0, 1'b1}) begin
            fails++;
            $display("FAIL invalid_again: got v=%b n=%h i=%b want v=1 n=0 i=1",
                     outValid, binaryNumber, isInvalid);
        end
    endtask

    // Leaves the previous invalid character pending so reset has something to drop.
    task automatic test_reset_mid();
        apply(7'b1111111, 1'b0);
        step(4);
        resetN = 1'b0;
        #1;
        tests_run++;
        if ({outValid, binaryNumber, isError, isInvalid, overrun} !== 8'b0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got %b want 00000000",
                     {outValid, binaryNumber, isError, isInvalid, overrun});
        end
        step(2);
        resetN = 1'b1;
        step(6);
        tests_run++;
        if (outValid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_early: outValid=%b want 0 after edge 5", outValid);
        end
        step(1);
        tests_run++;
        if ({outValid, binaryNumber, isInvalid} !== {1'b1, 4'h8, 1'b0}) begin
            fails++;
            $display("FAIL reset_mid_eight: got v=%b n=%h i=%b want v=1 n=8 i=0",
                     outValid, binaryNumber, isInvalid);
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_basic();
        test_glitch();
        test_dp_change();
        test_overrun();
        test_invalid();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
